// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI mode-0 responder, every pin oversampled in clk.
// One-word tx holding register, received-word strobe and underrun pulse.
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_write,
    output logic                  tx_full,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    if (SYNC_STAGES < 2 || DATA_WIDTH != 16) begin : g_bad_params
        $error("spi_slave: unsupported SYNC_STAGES or DATA_WIDTH");
    end

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_p;
    logic                   cs_p;

    logic                   sck_s;
    logic                   mosi_s;
    logic                   cs_s;
    logic                   rise;
    logic                   fall;

    logic [DATA_WIDTH-1:0]  tx_hold;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [CW-1:0]          bit_cnt;
    logic                   load_pending;
    logic                   word_end;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign rise = sck_s & ~sck_p;
    assign fall = ~sck_s & sck_p;
    assign busy = ~cs_s & (bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_p     <= 1'b0;
            cs_p      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_p     <= sck_s;
            cs_p      <= cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_hold      <= '0;
            tx_full      <= 1'b0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            underrun     <= 1'b0;
            miso         <= 1'b0;
            bit_cnt      <= '0;
            load_pending <= 1'b1;
            word_end     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;

            if (cs_s) begin
                bit_cnt      <= '0;
                rx_shift     <= '0;
                miso         <= 1'b0;
                load_pending <= 1'b1;
                word_end     <= 1'b0;
            end else begin
                // Next-word load: holding register if present, else zeros.
                if (load_pending && tx_full) begin
                    tx_shift     <= tx_hold;
                    miso         <= tx_hold[DATA_WIDTH-1];
                    tx_full      <= 1'b0;
                    load_pending <= 1'b0;
                end else if (load_pending && rise) begin
                    tx_shift     <= '0;
                    miso         <= 1'b0;
                    underrun     <= 1'b1;
                    load_pending <= 1'b0;
                end

                if (rise) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt == LAST) begin
                        rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        word_end <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                if (fall) begin
                    if (word_end) begin
                        word_end     <= 1'b0;
                        load_pending <= 1'b1;
                    end else begin
                        tx_shift <= tx_shift << 1;
                        miso     <= tx_shift[DATA_WIDTH-2];
                    end
                end
            end

            // A write coinciding with a load keeps the new word queued.
            if (tx_write) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

endmodule
